// File: rtl/id_stage_pipe.sv
// Decode stage: decode, condition check, register file with write-through bypass, hazard detect, ID/EX register.
// Latency: 1 cycle from instr to ex_* outputs. hazard is combinational from the current instruction.
// Backpressure: hazard stalls IF and inserts a bubble; flush squashes the bubble's control bits.
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int ADDR_W  = 4,
  parameter int FWD_EN  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr,
  input  logic [3:0]        status,
  input  logic              wb_en_in,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [ADDR_W-1:0] exe_dest,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic              exe_wb_en,
  input  logic              mem_wb_en,
  input  logic              exe_mem_read,
  input  logic              flush,
  output logic              hazard,
  output logic [31:0]       ex_pc,
  output logic [3:0]        ex_exe_cmd,
  output logic              ex_wb_en,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_s,
  output logic              ex_b,
  output logic              ex_imm,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [11:0]       ex_shift_op,
  output logic [23:0]       ex_signed_imm,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [ADDR_W-1:0] ex_src1,
  output logic [ADDR_W-1:0] ex_src2,
  output logic              ex_two_src
);

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
    logic       s;
    logic       b;
  } ctrl_t;

  localparam logic [ADDR_W:0] REG_LIM = (ADDR_W + 1)'(REG_CNT);

  logic [1:0]        mode;
  logic [3:0]        op;
  logic              s_bit, i_bit, store, two_src, cond_ok, hz_raw;
  logic [ADDR_W-1:0] src1, src2, dest;
  logic [DATA_W-1:0] val_rn, val_rm;
  logic [DATA_W-1:0] regs [REG_CNT];
  ctrl_t             ctrl_dec, ctrl_id, ex_ctrl;

  assign mode    = instr[27:26];
  assign op      = instr[24:21];
  assign s_bit   = instr[20];
  assign i_bit   = instr[25];
  assign store   = (mode == 2'b01) && !s_bit;
  assign two_src = !i_bit || store;
  assign src1    = ADDR_W'(instr[19:16]);
  assign src2    = store ? ADDR_W'(instr[15:12]) : ADDR_W'(instr[3:0]);
  assign dest    = ADDR_W'(instr[15:12]);

  always_comb begin
    ctrl_dec = '0;
    case (mode)
      2'b00: begin
        ctrl_dec.s = s_bit;
        case (op)
          4'b1101: begin ctrl_dec.exe_cmd = 4'b0001; ctrl_dec.wb_en = 1'b1; end
          4'b1111: begin ctrl_dec.exe_cmd = 4'b1001; ctrl_dec.wb_en = 1'b1; end
          4'b0100: begin ctrl_dec.exe_cmd = 4'b0010; ctrl_dec.wb_en = 1'b1; end
          4'b0101: begin ctrl_dec.exe_cmd = 4'b0011; ctrl_dec.wb_en = 1'b1; end
          4'b0010: begin ctrl_dec.exe_cmd = 4'b0100; ctrl_dec.wb_en = 1'b1; end
          4'b0110: begin ctrl_dec.exe_cmd = 4'b0101; ctrl_dec.wb_en = 1'b1; end
          4'b0000: begin ctrl_dec.exe_cmd = 4'b0110; ctrl_dec.wb_en = 1'b1; end
          4'b1100: begin ctrl_dec.exe_cmd = 4'b0111; ctrl_dec.wb_en = 1'b1; end
          4'b0001: begin ctrl_dec.exe_cmd = 4'b1000; ctrl_dec.wb_en = 1'b1; end
          4'b1010: ctrl_dec.exe_cmd = 4'b0100;
          4'b1000: ctrl_dec.exe_cmd = 4'b0110;
          default: ;
        endcase
      end
      2'b01: begin
        ctrl_dec.exe_cmd   = 4'b0010;
        ctrl_dec.mem_read  = s_bit;
        ctrl_dec.wb_en     = s_bit;
        ctrl_dec.mem_write = !s_bit;
      end
      2'b10:   ctrl_dec.b = 1'b1;
      default: ;
    endcase
  end

  // status = {N,Z,C,V}
  always_comb begin
    case (instr[31:28])
      4'h0:    cond_ok = status[2];
      4'h1:    cond_ok = !status[2];
      4'h2:    cond_ok = status[1];
      4'h3:    cond_ok = !status[1];
      4'h4:    cond_ok = status[3];
      4'h5:    cond_ok = !status[3];
      4'h6:    cond_ok = status[0];
      4'h7:    cond_ok = !status[0];
      4'h8:    cond_ok = status[1] && !status[2];
      4'h9:    cond_ok = !status[1] || status[2];
      4'hA:    cond_ok = status[3] == status[0];
      4'hB:    cond_ok = status[3] != status[0];
      4'hC:    cond_ok = !status[2] && (status[3] == status[0]);
      4'hD:    cond_ok = status[2] || (status[3] != status[0]);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign ctrl_id = cond_ok ? ctrl_dec : '0;

  // Write-through: a same-cycle writeback wins over the stored entry.
  assign val_rn = ({1'b0, src1} >= REG_LIM) ? '0 :
                  (wb_en_in && wb_dest == src1) ? wb_value : regs[src1];
  assign val_rm = ({1'b0, src2} >= REG_LIM) ? '0 :
                  (wb_en_in && wb_dest == src2) ? wb_value : regs[src2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wb_en_in && ({1'b0, wb_dest} < REG_LIM)) begin
      regs[wb_dest] <= wb_value;
    end
  end

  always_comb begin
    if (FWD_EN != 0)
      hz_raw = exe_mem_read && ((src1 == exe_dest) || (two_src && src2 == exe_dest));
    else
      hz_raw = (exe_wb_en && src1 == exe_dest) || (mem_wb_en && src1 == mem_dest) ||
               (two_src && ((exe_wb_en && src2 == exe_dest) || (mem_wb_en && src2 == mem_dest)));
  end

  assign hazard = (mode != 2'b10) && hz_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_ctrl       <= '0;
      ex_pc         <= '0;
      ex_imm        <= 1'b0;
      ex_val_rn     <= '0;
      ex_val_rm     <= '0;
      ex_shift_op   <= '0;
      ex_signed_imm <= '0;
      ex_dest       <= '0;
      ex_src1       <= '0;
      ex_src2       <= '0;
      ex_two_src    <= 1'b0;
    end else begin
      ex_ctrl       <= (flush || hazard) ? '0 : ctrl_id;
      ex_pc         <= pc_in;
      ex_imm        <= i_bit;
      ex_val_rn     <= val_rn;
      ex_val_rm     <= val_rm;
      ex_shift_op   <= instr[11:0];
      ex_signed_imm <= instr[23:0];
      ex_dest       <= dest;
      ex_src1       <= src1;
      ex_src2       <= src2;
      ex_two_src    <= two_src;
    end
  end

  assign ex_exe_cmd   = ex_ctrl.exe_cmd;
  assign ex_wb_en     = ex_ctrl.wb_en;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_s         = ex_ctrl.s;
  assign ex_b         = ex_ctrl.b;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (FWD_EN=0 with 16 regs, FWD_EN=1 with 12 regs) share stimulus;
// a reference model fills scoreboard queues that a separate monitor drains.
module tb_id_stage_pipe;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] pc_in, instr, wb_value;
  logic [3:0]  status, wb_dest, exe_dest, mem_dest;
  logic        wb_en_in, exe_wb_en, mem_wb_en, exe_mem_read, flush;

  logic        hz[2], o_wb[2], o_mr[2], o_mw[2], o_s[2], o_b[2], o_imm[2], o_two[2];
  logic [31:0] o_pc[2], o_rn[2], o_rm[2];
  logic [3:0]  o_cmd[2], o_dest[2], o_s1[2], o_s2[2];
  logic [11:0] o_sh[2];
  logic [23:0] o_simm[2];

  typedef struct packed { logic chk; logic [1:0] h; } hz_t;
  typedef struct packed {
    logic [8:0] c0, c1; logic [145:0] d0, d1; logic dchk0, dchk1;
  } ex_t;

  hz_t         hz_q[$];
  ex_t         ex_q[$];
  logic [31:0] mreg [2][16];
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(32), .REG_CNT(16), .ADDR_W(4), .FWD_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr(instr), .status(status),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_read(exe_mem_read), .flush(flush), .hazard(hz[0]), .ex_pc(o_pc[0]),
    .ex_exe_cmd(o_cmd[0]), .ex_wb_en(o_wb[0]), .ex_mem_read(o_mr[0]), .ex_mem_write(o_mw[0]),
    .ex_s(o_s[0]), .ex_b(o_b[0]), .ex_imm(o_imm[0]), .ex_val_rn(o_rn[0]), .ex_val_rm(o_rm[0]),
    .ex_shift_op(o_sh[0]), .ex_signed_imm(o_simm[0]), .ex_dest(o_dest[0]), .ex_src1(o_s1[0]),
    .ex_src2(o_s2[0]), .ex_two_src(o_two[0]));

  id_stage_pipe #(.DATA_W(32), .REG_CNT(12), .ADDR_W(4), .FWD_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr(instr), .status(status),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_read(exe_mem_read), .flush(flush), .hazard(hz[1]), .ex_pc(o_pc[1]),
    .ex_exe_cmd(o_cmd[1]), .ex_wb_en(o_wb[1]), .ex_mem_read(o_mr[1]), .ex_mem_write(o_mw[1]),
    .ex_s(o_s[1]), .ex_b(o_b[1]), .ex_imm(o_imm[1]), .ex_val_rn(o_rn[1]), .ex_val_rm(o_rm[1]),
    .ex_shift_op(o_sh[1]), .ex_signed_imm(o_simm[1]), .ex_dest(o_dest[1]), .ex_src1(o_s1[1]),
    .ex_src2(o_s2[1]), .ex_two_src(o_two[1]));

  // ARM condition codes come in complementary pairs; the odd code inverts its even partner.
  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n = f[3], z = f[2], c = f[1], v = f[0], base;
    if (cc == 4'hF) return 1'b0;
    if (cc == 4'hE) return 1'b1;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  function automatic void dp_op(input logic [3:0] op, output logic [3:0] cmd, output bit wb);
    wb = 1'b1;
    case (op)
      4'b1101: cmd = 4'd1;  4'b1111: cmd = 4'd9;  4'b0100: cmd = 4'd2;
      4'b0101: cmd = 4'd3;  4'b0010: cmd = 4'd4;  4'b0110: cmd = 4'd5;
      4'b0000: cmd = 4'd6;  4'b1100: cmd = 4'd7;  4'b0001: cmd = 4'd8;
      4'b1010: begin cmd = 4'd4; wb = 1'b0; end
      4'b1000: begin cmd = 4'd6; wb = 1'b0; end
      default: begin cmd = 4'd0; wb = 1'b0; end
    endcase
  endfunction

  function automatic logic [31:0] rd(input int k, input logic [3:0] idx);
    int rc = (k == 0) ? 16 : 12;
    if (int'(idx) >= rc) return 32'd0;
    if (wb_en_in && wb_dest == idx) return wb_value;
    return mreg[k][idx];
  endfunction

  task automatic model_push();
    hz_t he; ex_t ee;
    logic [1:0] mode = instr[27:26];
    bit ib = instr[25], sb = instr[20];
    bit store = (mode == 2'd1) && !sb;
    bit two = !ib || store;
    logic [3:0] s1 = instr[19:16];
    logic [3:0] s2 = store ? instr[15:12] : instr[3:0];
    logic [3:0] cmd = 4'd0;
    bit wb = 0, mr = 0, mw = 0, so = 0, bo = 0, h, dchk;
    logic [8:0] c; logic [145:0] d;
    case (mode)
      2'd0: begin dp_op(instr[24:21], cmd, wb); so = sb; end
      2'd1: begin cmd = 4'd2; mr = sb; wb = sb; mw = !sb; end
      2'd2: bo = 1'b1;
      default: ;
    endcase
    if (!cond_ok(instr[31:28], status)) begin cmd = 0; wb = 0; mr = 0; mw = 0; so = 0; bo = 0; end
    he.chk = rst;
    for (int k = 0; k < 2; k++) begin
      if (k == 0)
        h = (exe_wb_en && s1 == exe_dest) || (mem_wb_en && s1 == mem_dest) ||
            (two && ((exe_wb_en && s2 == exe_dest) || (mem_wb_en && s2 == mem_dest)));
      else
        h = exe_mem_read && (s1 == exe_dest || (two && s2 == exe_dest));
      h = h && (mode != 2'd2);
      he.h[k] = h;
      c = {cmd, wb, mr, mw, so, bo};
      d = {pc_in, ib, rd(k, s1), rd(k, s2), instr[11:0], instr[23:0], instr[15:12], s1, s2, two};
      dchk = 1'b1;
      if (!rst) begin c = '0; d = '0; end
      else if (flush || h) begin c = '0; dchk = 1'b0; end
      if (k == 0) begin ee.c0 = c; ee.d0 = d; ee.dchk0 = dchk; end
      else        begin ee.c1 = c; ee.d1 = d; ee.dchk1 = dchk; end
    end
    hz_q.push_back(he);
    ex_q.push_back(ee);
    for (int k = 0; k < 2; k++) begin
      if (!rst) for (int r = 0; r < 16; r++) mreg[k][r] = 32'd0;
      else if (wb_en_in && int'(wb_dest) < ((k == 0) ? 16 : 12)) mreg[k][wb_dest] = wb_value;
    end
  endtask

  task automatic check(input string name, input int k, input logic [145:0] act, input logic [145:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic logic [145:0] act_data(input int k);
    return {o_pc[k], o_imm[k], o_rn[k], o_rm[k], o_sh[k], o_simm[k], o_dest[k], o_s1[k], o_s2[k], o_two[k]};
  endfunction

  // Monitor: hazard is checked mid-cycle, the ID/EX register just after the edge.
  initial begin
    hz_t he; ex_t ee;
    forever begin
      @(negedge clk);
      if (hz_q.size() != 0) begin
        he = hz_q.pop_front();
        if (he.chk)
          for (int k = 0; k < 2; k++) check("hazard", k, 146'(hz[k]), 146'(he.h[k]));
      end
      @(posedge clk);
      #1;
      if (ex_q.size() != 0) begin
        ee = ex_q.pop_front();
        check("ctrl", 0, 146'({o_cmd[0], o_wb[0], o_mr[0], o_mw[0], o_s[0], o_b[0]}), 146'(ee.c0));
        check("ctrl", 1, 146'({o_cmd[1], o_wb[1], o_mr[1], o_mw[1], o_s[1], o_b[1]}), 146'(ee.c1));
        if (ee.dchk0) check("data", 0, act_data(0), ee.d0);
        if (ee.dchk1) check("data", 1, act_data(1), ee.d1);
      end
    end
  end

  task automatic cycle();
    model_push();
    @(posedge clk);
    #2;
    pc_in = pc_in + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout queues=%0d/%0d", hz_q.size(), ex_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) for (int r = 0; r < 16; r++) mreg[k][r] = 32'd0;
    rst = 0; pc_in = 32'h100; instr = 32'h0; status = 4'h0; wb_en_in = 0; wb_dest = 0;
    wb_value = 0; exe_dest = 0; mem_dest = 0; exe_wb_en = 0; mem_wb_en = 0;
    exe_mem_read = 0; flush = 0;
    cycle(); cycle();
    rst = 1; instr = 32'hE3A01010; cycle();                         // MOV R1,#0x10
    instr = 32'hE0852005; cycle();                                  // ADD R2,R5,R5 reads zero
    wb_en_in = 1; wb_dest = 3; wb_value = 32'hDEADBEEF;
    instr = 32'hE0832003; cycle();                                  // ADD R2,R3,R3 bypass
    wb_en_in = 0;
    exe_dest = 3; exe_wb_en = 1; instr = 32'hE0832004; cycle();     // ADD R2,R3,R4 stalls
    exe_wb_en = 0; cycle();
    exe_mem_read = 1; instr = 32'hE2435001; cycle();                // SUB R5,R3,#1 load-use
    exe_mem_read = 0; cycle();
    status = 4'b0000; instr = 32'h00832004; cycle();                // ADDEQ fails
    status = 4'b0100; cycle();
    exe_dest = 2; exe_wb_en = 1; flush = 1; instr = 32'hE5821000; cycle(); // STR R1,[R2]
    rst = 0; cycle();
    rst = 1; flush = 0; exe_wb_en = 0;
    wb_en_in = 1; wb_dest = 13; wb_value = 32'h1234_5678;
    instr = 32'hE08D200D; cycle();                                  // R13 out of range on dut1
    wb_en_in = 0; cycle();
    for (int i = 0; i < 500; i++) begin
      instr = $urandom;
      if ($urandom_range(3) != 0) instr[31:28] = 4'hE;
      status       = 4'($urandom);
      wb_en_in     = 1'($urandom);
      wb_dest      = 4'($urandom);
      wb_value     = $urandom;
      exe_dest     = 4'($urandom);
      mem_dest     = 4'($urandom);
      exe_wb_en    = ($urandom_range(3) == 0);
      mem_wb_en    = ($urandom_range(3) == 0);
      exe_mem_read = ($urandom_range(2) == 0);
      flush        = ($urandom_range(15) == 0);
      rst          = ($urandom_range(63) != 0);
      cycle();
    end
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (hz_q.size() != 0 || ex_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d/%0d required=0/0", hz_q.size(), ex_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
